pwm_capture: RTL and testbench

Measures an incoming single-bit PWM waveform and recovers its period, high time and 7-bit duty code. This is the receive-side counterpart of the DDS PWM generator: a waveform produced with duty code D and a 128-clock period is decoded back to D. It sits on the loopback/measurement path of the DDS fabric, runs off the same clock, and reports one result per completed period.

---
 rtl/pwm_capture.sv | 174 +++++++++++++++++
 tb/tb_pwm_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time/duty-code capture with iterative duty divider
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic [6:0]       duty_out,
    output logic             stuck,
    output logic             valid,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       period_cnt, high_cnt, s_ext;

    logic                   div_busy, div_done, div_free, div_ge;
    logic [3:0]             div_iter;
    logic [CNT_W-1:0]       div_p, div_h;
    logic [CNT_W:0]         div_rem, div_diff;
    logic [7:0]             div_q, q_m1;
    logic [6:0]             duty_calc;

    logic start_div, drop, timeout, cnt_restart, cnt_step;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~s_d;
    assign s_ext = {{(CNT_W-1){1'b0}}, s};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    // The divider may accept a new snapshot on the same edge it retires the previous one.
    assign div_done = div_busy && (div_iter == 4'd8);
    assign div_free = !div_busy || div_done;

    // One restoring step per clock: remainder is kept pre-scaled so H*128 never needs widening.
    assign div_ge    = div_rem >= {1'b0, div_p};
    assign div_diff  = div_ge ? (div_rem - {1'b0, div_p}) : div_rem;
    assign q_m1      = div_q - 8'd1;
    assign duty_calc = (div_q == 8'd0) ? 7'd0 : (div_q[7] ? 7'h7f : q_m1[6:0]);

    always_comb begin
        state_d     = state_q;
        start_div   = 1'b0;
        drop        = 1'b0;
        timeout     = 1'b0;
        cnt_restart = 1'b0;
        cnt_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d     = MEASURE;
                    cnt_restart = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    cnt_restart = 1'b1;
                    if (div_free) start_div = 1'b1;
                    else          drop      = 1'b1;
                end else if (period_cnt == CNT_MAX) begin
                    // Timeout waits for any in-flight result so that one is reported first.
                    if (!div_busy) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d     = IDLE;
            start_div   = 1'b0;
            drop        = 1'b0;
            timeout     = 1'b0;
            cnt_restart = 1'b0;
            cnt_step    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            div_busy   <= 1'b0;
            div_iter   <= '0;
            div_p      <= '0;
            div_h      <= '0;
            div_rem    <= '0;
            div_q      <= '0;
            period_out <= '0;
            high_out   <= '0;
            duty_out   <= '0;
            stuck      <= 1'b0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid   <= 1'b0;
            overrun <= drop;
            if (!enable) begin
                period_cnt <= '0;
                high_cnt   <= '0;
                div_busy   <= 1'b0;
            end else begin
                if (cnt_restart) begin
                    period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                    high_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (cnt_step) begin
                    period_cnt <= period_cnt + 1'b1;
                    high_cnt   <= high_cnt + s_ext;
                end else if (timeout) begin
                    period_cnt <= '0;
                    high_cnt   <= '0;
                end

                if (div_busy && !div_done) begin
                    div_rem  <= {div_diff[CNT_W-1:0], 1'b0};
                    div_q    <= {div_q[6:0], div_ge};
                    div_iter <= div_iter + 4'd1;
                end

                if (div_done) begin
                    period_out <= div_p;
                    high_out   <= div_h;
                    duty_out   <= duty_calc;
                    stuck      <= 1'b0;
                    valid      <= 1'b1;
                    div_busy   <= 1'b0;
                end

                if (start_div) begin
                    div_p    <= period_cnt;
                    div_h    <= high_cnt;
                    div_rem  <= {1'b0, high_cnt};
                    div_q    <= '0;
                    div_iter <= '0;
                    div_busy <= 1'b1;
                end

                if (timeout) begin
                    period_out <= '0;
                    high_out   <= '0;
                    duty_out   <= s ? 7'h7f : 7'd0;
                    stuck      <= 1'b1;
                    valid      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized and directed bench for pwm_capture against a period-level model
module tb_pwm_capture;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset, enable, pwm_in;
    logic [15:0] per16, high16;
    logic [6:0]  duty16;
    logic        stuck16, valid16, ov16;
    logic [7:0]  per8, high8;
    logic [6:0]  duty8;
    logic        stuck8, valid8, ov8;

    pwm_capture #(.CNT_W(16), .SYNC_STAGES(SS)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .period_out(per16), .high_out(high16), .duty_out(duty16),
        .stuck(stuck16), .valid(valid16), .overrun(ov16)
    );

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(SS)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .period_out(per8), .high_out(high8), .duty_out(duty8),
        .stuck(stuck8), .valid(valid8), .overrun(ov8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ov_cnt16 = 0;

    // Model: index 0 tracks the 16-bit instance, index 1 the 8-bit instance.
    int cyc = 0;
    int last_rst = 0;
    bit hist[16];
    int maxc[2] = '{65535, 255};
    bit m_meas[2], m_pend[2];
    int m_last[2], m_hi[2], m_pend_end[2], m_pend_p[2], m_pend_h[2];
    int e_per[2], e_high[2], e_duty[2];
    bit e_stuck[2], e_valid[2], e_ov[2];

    function automatic bit s_at(input int m);
        if (m - SS > last_rst) return hist[(m - SS) % 16];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int  m, q;
        bit  r, emitted;
        cyc = cyc + 1;
        m = cyc;
        hist[m % 16] = pwm_in;
        if (reset) last_rst = m;
        r = s_at(m) && !s_at(m - 1);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_meas[i] = 0; m_pend[i] = 0; m_hi[i] = 0;
                e_per[i] = 0; e_high[i] = 0; e_duty[i] = 0;
                e_stuck[i] = 0; e_valid[i] = 0; e_ov[i] = 0;
            end else if (!enable) begin
                m_meas[i] = 0; m_pend[i] = 0;
                e_valid[i] = 0; e_ov[i] = 0;
            end else begin
                e_valid[i] = 0;
                e_ov[i] = 0;
                emitted = 0;
                if (m_pend[i] && m_pend_end[i] == m) begin
                    q = (m_pend_h[i] * 128) / m_pend_p[i];
                    e_per[i]   = m_pend_p[i];
                    e_high[i]  = m_pend_h[i];
                    e_duty[i]  = (q == 0) ? 0 : ((q - 1 > 127) ? 127 : q - 1);
                    e_stuck[i] = 0;
                    e_valid[i] = 1;
                    m_pend[i]  = 0;
                    emitted    = 1;
                end
                if (r) begin
                    if (m_meas[i]) begin
                        if (m_pend[i]) e_ov[i] = 1;
                        else begin
                            m_pend[i]     = 1;
                            m_pend_end[i] = m + 9;
                            m_pend_p[i]   = m - m_last[i];
                            m_pend_h[i]   = m_hi[i];
                        end
                    end
                    m_meas[i] = 1;
                    m_last[i] = m;
                    m_hi[i]   = 1;
                end else if (m_meas[i]) begin
                    if (m - m_last[i] >= maxc[i]) begin
                        if (!m_pend[i] && !emitted) begin
                            e_per[i]   = 0;
                            e_high[i]  = 0;
                            e_duty[i]  = s_at(m) ? 127 : 0;
                            e_stuck[i] = 1;
                            e_valid[i] = 1;
                            m_meas[i]  = 0;
                        end
                    end else begin
                        m_hi[i] = m_hi[i] + int'(s_at(m));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [41:0] act, expv;
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                if (i == 0) act = {valid16, ov16, stuck16, duty16, per16, high16};
                else        act = {valid8, ov8, stuck8, duty8, 8'd0, per8, 8'd0, high8};
                expv = {e_valid[i], e_ov[i], e_stuck[i], e_duty[i][6:0], e_per[i][15:0], e_high[i][15:0]};
                checks++;
                if (act !== expv) begin
                    errors++;
                    $display("FAIL model_dut%0d cyc=%0d actual={v,ov,stuck,duty,per,high}=%h required=%h",
                             i, cyc, act, expv);
                end
            end
            if (ov16) ov_cnt16++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic run_wave(input int t, input int h, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            tick(h);
            pwm_in = 1'b0;
            tick(t - h);
        end
    endtask

    int ov_before;
    int sweep_d[4] = '{0, 1, 63, 126};

    initial begin
        reset = 1'b1; enable = 1'b1; pwm_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        lit("reset_period", int'(per16), 0);
        lit("reset_high", int'(high16), 0);
        lit("reset_duty", int'(duty16), 0);
        lit("reset_stuck", int'(stuck16), 0);

        run_wave(128, 65, 6);
        lit("d64_period", int'(per16), 128);
        lit("d64_high", int'(high16), 65);
        lit("d64_duty", int'(duty16), 64);

        for (int k = 0; k < 4; k++) begin
            run_wave(128, sweep_d[k] + 1, 3);
            lit("sweep_duty", int'(duty16), sweep_d[k]);
            lit("sweep_high", int'(high16), sweep_d[k] + 1);
        end

        pwm_in = 1'b1;
        tick(65600);
        lit("d127_stuck", int'(stuck16), 1);
        lit("d127_duty", int'(duty16), 127);
        lit("d127_period", int'(per16), 0);
        lit("d127_stuck8", int'(stuck8), 1);

        run_wave(200, 50, 5);
        lit("p200_duty", int'(duty16), 31);
        lit("p200_period", int'(per16), 200);
        lit("p200_high", int'(high16), 50);

        ov_before = ov_cnt16;
        run_wave(6, 3, 20);
        lit("p6_overruns", ov_cnt16 - ov_before, 10);
        lit("p6_period", int'(per16), 6);
        lit("p6_high", int'(high16), 3);

        run_wave(9, 4, 2);
        ov_before = ov_cnt16;
        run_wave(9, 4, 8);
        lit("p9_overruns", ov_cnt16 - ov_before, 0);
        lit("p9_duty", int'(duty16), 55);

        pwm_in = 1'b0;
        tick(300);
        lit("low_stuck8", int'(stuck8), 1);
        lit("low_duty8", int'(duty8), 0);
        lit("low_period8", int'(per8), 0);

        run_wave(128, 65, 3);
        pwm_in = 1'b1;
        tick(5);
        enable = 1'b0;
        tick(3);
        lit("en_hold_period", int'(per16), 128);
        lit("en_hold_duty", int'(duty16), 64);
        enable = 1'b1;
        tick(60);
        pwm_in = 1'b0;
        tick(63);
        run_wave(128, 65, 3);
        pwm_in = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        lit("rst_period", int'(per16), 0);
        lit("rst_duty", int'(duty16), 0);
        lit("rst_valid", int'(valid16), 0);
        tick(60);
        pwm_in = 1'b0;
        tick(63);
        run_wave(128, 65, 3);

        for (int k = 0; k < 20; k++) begin
            int t, h, n;
            t = int'($urandom_range(300, 4));
            h = int'($urandom_range(t - 1, 1));
            n = int'($urandom_range(3, 2));
            run_wave(t, h, n);
            if ($urandom_range(7, 0) == 0) begin
                enable = 1'b0;
                tick(int'($urandom_range(20, 1)));
                enable = 1'b1;
            end
            if ($urandom_range(11, 0) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
        end
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
